ddr_clk_sequencer: RTL and testbench
====================================

# ddr_clk_sequencer

Runtime-programmable controller that sequences the two DDR data bits of one SB_IO output register to synthesise a divided clock with half-cycle resolution (divide-by-N, N = 2..2^DIV_W-1, 50 % duty for odd N). Sits between the PLL global clock and a clock-output pad. It also manages glitch-free divisor changes, start/stop at period boundaries, and a common restart so several channels stay phase-aligned.

## Interface
- DIV_W, 5: width of divisor and phase counter.
- DEFAULT_DIV, 7: divisor loaded at reset; must be 2..2^DIV_W-1.

- clkin  input  1  PLL global clock; also drives the SB_IO OUTPUT_CLK.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run request; sampled every cycle.
- sync_in  input  1  restart pulse; forces phase 0 on the next edge.
- cfg_div  input  DIV_W  requested divisor.
- cfg_valid  input  1  cfg_div valid.
- cfg_ready  output  1  high when no divisor is pending.
- cfg_err  output  1  one-cycle pulse: the accepted cfg_div was < 2 and was discarded.
- dout0  output  1  rising-edge half bit, to SB_IO D_OUT_0.
- dout1  output  1  falling-edge half bit, to SB_IO D_OUT_1.
- period_start  output  1  one-cycle pulse, coincident with phase 0 output.
- cur_div  output  DIV_W  active divisor.
- running  output  1  high in RUN.

## Operation
- States: IDLE and RUN. Registers: phase (DIV_W), cur_div, pend_div, pend_valid.
- Pattern for phase p, with hi = cur_div >> 1:
  - p < hi gives {dout1,dout0} = 11.
  - p == hi and cur_div is odd gives 01 (high for the first half only).
  - Otherwise 00.
  - Example N=7: 11,11,11,01,00,00,00. Example N=8: 4×11 then 4×00.
- IDLE: outputs 00, phase held at 0.
  - If pend_valid, cur_div <= pend_div and pend_valid clears on that edge.
  - enable=1 or sync_in=1 with enable=1: go to RUN with phase 0 on the next edge, applying any pending divisor on that same edge.
- RUN: phase increments each cycle. At the last phase (cur_div-1):
  - If pend_valid, load cur_div <= pend_div and clear pend_valid.
  - If enable=0, go to IDLE; otherwise phase wraps to 0.
  - enable dropping mid-period never truncates the period: the full pattern completes.
- sync_in=1 in RUN: the next edge gives phase 0 regardless of the current phase, applies any pending divisor, and stays in RUN if enable=1 (IDLE if enable=0).
- Priority: reset > sync_in > period boundary > increment.
- Config handshake:
  - A transfer happens when cfg_valid && cfg_ready.
  - cfg_ready = !pend_valid.
  - A value ≥ 2 sets pend_div and pend_valid.
  - A value < 2 leaves the pending state unchanged and pulses cfg_err on the next cycle.
  - A transfer on the same edge as a boundary becomes pending. It is applied at the following boundary, not the current one.
- Reset values:
  - State IDLE, phase 0, dout0 = dout1 = 0, period_start 0, running 0.
  - cur_div = DEFAULT_DIV, pend_valid 0, cfg_ready 1, cfg_err 0.

## Timing
- All outputs are registered and update on the rising edge of clkin.
- dout0, dout1 and period_start always reflect the same phase value.
- Start latency: enable sampled high at edge t gives phase 0 (pattern 11, period_start=1) after edge t+1.
- Output clock period is exactly cur_div clkin cycles. No short or long period occurs across a divisor change: the change lands only on phase 0.
- Stop latency: 0 to cur_div-1 cycles (remainder of the current period), then 00 from the next edge.
- A sync_in pulse at edge t gives phase 0 after edge t+1. Two channels given the same sync_in produce coincident period_start pulses.
- Reset mid-period: outputs are 00 after the next edge. No partial pulse is emitted afterwards.

## Test plan
- Reset, then enable=1 with DEFAULT_DIV=7 → 7-cycle repeat of 11,11,11,01,00,00,00. period_start every 7 cycles. cur_div=7.
- While running at 7, load cfg_div=8 at phase 2 → cfg_ready low until the boundary. Remaining phases of the 7-pattern complete, then 4×11 and 4×00. cur_div changes exactly at phase 0.
- cfg_div=1 handshake → cfg_err pulses one cycle. cur_div and the pattern are unchanged. cfg_ready stays 1.
- enable dropped at phase 1 with N=5 → phases 2..4 (01,00,00) are emitted, then constant 00 and running=0. Re-enable → 11 after one edge.
- Two instances at N=7 and N=8, sync_in pulsed once → both show period_start on the same cycle, then realign every 56 cycles.
- Reset asserted at phase 3 with N=8 → dout 00 next cycle. cur_div=7, cfg_ready=1, running=0.

Source files
------------

// File: rtl/ddr_clk_sequencer.sv
// Drives the two DDR half-bits of an SB_IO output register to synthesise a divide-by-N
// clock (half-cycle resolution). Divisor changes, stop and restart all land on phase 0.
module ddr_clk_sequencer #(
  parameter int DIV_W       = 5,
  parameter int DEFAULT_DIV = 7
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_in,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             dout0,
  output logic             dout1,
  output logic             period_start,
  output logic [DIV_W-1:0] cur_div,
  output logic             running,
  output logic             state_dbg
);

  // Config handshake: a divisor transfers on any edge where cfg_valid && cfg_ready.
  // cfg_ready is low while a divisor is pending; the pending value is applied only on
  // an edge that moves the phase to 0, so the output never sees a short or long period.

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic             apply_pend;
  logic             last_phase;
  logic             cfg_xfer;
  logic             cfg_bad;
  logic [DIV_W-1:0] half_div;
  logic             div_odd;

  assign last_phase = (phase_q == (cur_div_q - DIV_W'(1)));
  assign cfg_xfer   = cfg_valid && !pend_valid_q;
  assign cfg_bad    = cfg_xfer && (cfg_div < DIV_W'(2));
  assign cfg_ready  = !pend_valid_q;
  assign state_dbg  = (state_q == RUN);
  assign half_div   = cur_div_q >> 1;
  assign div_odd    = cur_div_q[0];

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    apply_pend = 1'b0;
    case (state_q)
      IDLE: begin
        phase_d    = '0;
        apply_pend = 1'b1;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (sync_in) begin
          phase_d    = '0;
          apply_pend = 1'b1;
          state_d    = enable ? RUN : IDLE;
        end else if (last_phase) begin
          phase_d    = '0;
          apply_pend = 1'b1;
          if (!enable) state_d = IDLE;
        end else begin
          phase_d = phase_q + DIV_W'(1);
        end
      end
    endcase
  end

  // A transfer can only happen with nothing pending, so it never races the apply.
  always_comb begin
    cur_div_d    = cur_div_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;
    if (apply_pend && pend_valid_q) begin
      cur_div_d    = pend_div_q;
      pend_valid_d = 1'b0;
    end
    if (cfg_xfer && !cfg_bad) begin
      pend_div_d   = cfg_div;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      cur_div_q    <= DIV_W'(DEFAULT_DIV);
      pend_div_q   <= DIV_W'(DEFAULT_DIV);
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cur_div_q    <= cur_div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // Output stage: phase and divisor of the same period are registered together, so
  // dout0/dout1/period_start/cur_div/running always describe one phase value.
  always_ff @(posedge clkin) begin
    if (reset) begin
      dout0        <= 1'b0;
      dout1        <= 1'b0;
      period_start <= 1'b0;
      running      <= 1'b0;
      cfg_err      <= 1'b0;
      cur_div      <= DIV_W'(DEFAULT_DIV);
    end else begin
      cfg_err <= cfg_bad;
      cur_div <= cur_div_q;
      if (state_q == RUN) begin
        dout1        <= (phase_q < half_div);
        dout0        <= (phase_q < half_div) || ((phase_q == half_div) && div_odd);
        period_start <= (phase_q == '0);
        running      <= 1'b1;
      end else begin
        dout0        <= 1'b0;
        dout1        <= 1'b0;
        period_start <= 1'b0;
        running      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_clk_sequencer.sv
// Bench for ddr_clk_sequencer: directed scenarios plus random traffic, checked every cycle
// against a period-queue model built from the half-bit duty rule.
module tb_ddr_clk_sequencer;
  localparam int DIV_W = 5;
  localparam int DEFAULT_DIV = 7;

  logic             clkin = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             sync_in = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready, cfg_err, dout0, dout1, period_start, running, state_dbg;
  logic [DIV_W-1:0] cur_div;

  logic             enable1 = 1'b0;
  logic             zero_valid = 1'b0;
  logic [DIV_W-1:0] zero_div = '0;
  logic             b_ready, b_err, b_d0, b_d1, b_ps, b_run, b_dbg;
  logic [DIV_W-1:0] b_cur;

  ddr_clk_sequencer #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_dut (
    .clkin(clkin), .reset(reset), .enable(enable), .sync_in(sync_in),
    .cfg_div(cfg_div), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .dout0(dout0), .dout1(dout1), .period_start(period_start), .cur_div(cur_div),
    .running(running), .state_dbg(state_dbg)
  );

  ddr_clk_sequencer #(.DIV_W(DIV_W), .DEFAULT_DIV(8)) u_dut8 (
    .clkin(clkin), .reset(reset), .enable(enable1), .sync_in(sync_in),
    .cfg_div(zero_div), .cfg_valid(zero_valid), .cfg_ready(b_ready), .cfg_err(b_err),
    .dout0(b_d0), .dout1(b_d1), .period_start(b_ps), .cur_div(b_cur),
    .running(b_run), .state_dbg(b_dbg)
  );

  always #5 clkin = ~clkin;

  int errors = 0;
  int checks = 0;

  // Model: a queue holding the remaining {period_start, dout1, dout0} entries of the
  // current period. Half-bit k of an N-cycle period is high when k < N.
  bit               m_run;
  logic [2:0]       m_q[$];
  int               m_div, m_per, m_pend_div;
  bit               m_pend_v;
  logic [2:0]       exp_pat;
  logic             exp_run;
  logic [DIV_W-1:0] exp_cur;

  function automatic void load_period();
    logic [2:0] e;
    m_q.delete();
    m_per = m_div;
    for (int p = 0; p < m_div; p++) begin
      e = {(p == 0), (2 * p + 1 < m_div), (2 * p < m_div)};
      m_q.push_back(e);
    end
  endfunction

  function automatic void take_pending();
    if (m_pend_v) begin
      m_div = m_pend_div;
      m_pend_v = 1'b0;
    end
  endfunction

  function automatic void snap();
    exp_pat = m_run ? m_q[0] : 3'b000;
    exp_run = m_run;
    exp_cur = m_div[DIV_W-1:0];
  endfunction

  function automatic int m_phase();
    return m_per - m_q.size();
  endfunction

  task automatic step(input string tag);
    bit xfer, bad, exp_err;
    @(posedge clkin);
    #1;
    xfer = cfg_valid && !m_pend_v;
    bad = xfer && (cfg_div < 2);
    if (reset) begin
      m_run = 0; m_q.delete(); m_div = DEFAULT_DIV; m_pend_v = 0; m_per = 0;
      exp_err = 0;
      snap();
    end
    checks++;
    if ({period_start, dout1, dout0} !== exp_pat) begin
      errors++;
      $display("FAIL %s pattern: got %b expected %b at %0t", tag,
               {period_start, dout1, dout0}, exp_pat, $time);
    end
    checks++;
    if (running !== exp_run || cur_div !== exp_cur) begin
      errors++;
      $display("FAIL %s running/cur_div: got %b/%0d expected %b/%0d at %0t", tag,
               running, cur_div, exp_run, exp_cur, $time);
    end
    if (!reset) begin
      exp_err = bad;
      if (!m_run) begin
        take_pending();
        if (enable) begin m_run = 1; load_period(); end
      end else if (sync_in) begin
        take_pending();
        if (enable) load_period();
        else begin m_run = 0; m_q.delete(); end
      end else begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          take_pending();
          if (enable) load_period();
          else m_run = 0;
        end
      end
      if (xfer && !bad) begin m_pend_div = cfg_div; m_pend_v = 1; end
      snap();
    end
    checks++;
    if (cfg_err !== exp_err || cfg_ready !== !m_pend_v) begin
      errors++;
      $display("FAIL %s cfg_err/cfg_ready: got %b/%b expected %b/%b at %0t", tag,
               cfg_err, cfg_ready, exp_err, !m_pend_v, $time);
    end
  endtask

  task automatic run_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic wait_phase(input string tag, input int ph);
    int guard = 0;
    while (!(m_run && m_phase() == ph) && guard < 64) begin
      step(tag);
      guard++;
    end
    checks++;
    if (guard >= 64) begin
      errors++;
      $display("FAIL %s phase wait: got timeout expected phase %0d", tag, ph);
    end
  endtask

  task automatic send_cfg(input string tag, input int d);
    cfg_div = d[DIV_W-1:0];
    cfg_valid = 1'b1;
    step(tag);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run_cycles("reset", 2);
    reset = 1'b0;
    run_cycles("idle", 4);
  endtask

  task automatic test_default_run();
    enable = 1'b1;
    run_cycles("run7", 22);
  endtask

  task automatic test_div_change();
    wait_phase("chg_wait", 2);
    send_cfg("chg_cfg", 8);
    run_cycles("chg_run", 24);
  endtask

  task automatic test_bad_cfg();
    send_cfg("bad1", 1);
    run_cycles("bad1_run", 4);
    send_cfg("bad0", 0);
    run_cycles("bad0_run", 10);
  endtask

  task automatic test_stop_start();
    send_cfg("stop_cfg", 5);
    run_cycles("stop_fill", 12);
    wait_phase("stop_wait", 1);
    enable = 1'b0;
    run_cycles("stop_drain", 10);
    enable = 1'b1;
    run_cycles("restart", 12);
  endtask

  task automatic test_sync_two();
    int coinc, first, last;
    send_cfg("sync_cfg", 7);
    enable1 = 1'b1;
    run_cycles("sync_fill", 16);
    sync_in = 1'b1;
    step("sync_pulse");
    sync_in = 1'b0;
    coinc = 0; first = -1; last = -1;
    for (int i = 0; i < 112; i++) begin
      step("sync_run");
      if (period_start && b_ps) begin
        coinc++;
        if (first < 0) first = i;
        last = i;
      end
    end
    checks++;
    if (coinc != 2 || first != 0 || last != 56) begin
      errors++;
      $display("FAIL sync_align: got count=%0d first=%0d last=%0d expected 2/0/56",
               coinc, first, last);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      sync_in = ($urandom_range(0, 29) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_div = DIV_W'($urandom_range(0, (1 << DIV_W) - 1));
      step("random");
    end
    sync_in = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    run_cycles("rmid_settle", 40);
    if (cur_div != 8) begin
      send_cfg("rmid_cfg", 8);
      run_cycles("rmid_fill", 40);
    end
    wait_phase("rmid_wait", 3);
    enable = 1'b0;
    reset = 1'b1;
    step("rmid_reset");
    reset = 1'b0;
    run_cycles("rmid_after", 6);
  endtask

  initial begin
    m_run = 0; m_div = DEFAULT_DIV; m_per = 0; m_pend_v = 0; m_pend_div = 0;
    snap();
    test_reset();
    test_default_run();
    test_div_change();
    test_bad_cfg();
    test_stop_start();
    test_sync_two();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
